// File: rtl/lnl_uart_pkg.sv
// Shared frame constants, line levels and FSM state encoding for the UART transmitter.
// LNL_UART_TX_PARITY_EN adds a parity bit (and the PARITY state) to every frame.
package lnl_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
`ifdef LNL_UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef LNL_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/lnl_uart_tx_if.sv
// Byte write channel (valid/ready) into the UART transmit FIFO.
interface lnl_uart_tx_if;
  import lnl_uart_pkg::*;

  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/lnl_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; head entry is visible on rd_data_c.
// DEPTH must be a power of two so the pointers wrap naturally.
module lnl_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CNT_W-1:0] count_next;

  // A write while full is dropped even if a pop happens on the same edge.
  assign do_wr     = wr_en & ~full;
  assign do_rd     = rd_en & ~empty;
  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/lnl_uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data bits LSB first, stop.
// Define LNL_UART_TX_PARITY_EN to insert a parity bit (XOR of data XOR parity_odd) before stop.
module lnl_uart_tx
  import lnl_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DIV_W-1:0] baud_div,
  lnl_uart_tx_if.slave     wr,
  input  logic             parity_odd,
  output logic             txd,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_START  = 3'(ST_START);
  localparam logic [2:0] S_DATA   = 3'(ST_DATA);
`ifdef LNL_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
`endif
  localparam logic [2:0] S_STOP   = 3'(ST_STOP);

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic                 pop;
  logic                 push;
  logic                 line_next;
  logic                 busy_next;
  logic                 bit_end;
  logic                 last_data;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [DATA_BITS-1:0] shift_q;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     baud_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;

  assign push        = wr.wr_valid & ~fifo_full;
  assign wr.wr_ready = ~fifo_full;

  lnl_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (push),
    .wr_data   (wr.wr_data),
    .rd_en     (pop),
    .rd_data_c (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_end   = (baud_cnt == div_q - DIV_W'(1));
  assign last_data = (bit_cnt == BIT_CNT_W'(DATA_BITS - 1));

`ifdef LNL_UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   parity_q <= 1'b0;
    else if (pop) parity_q <= (^fifo_head) ^ parity_odd;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state, FIFO pop and the line level owed to the current bit.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    line_next  = LINE_IDLE;
    case (state)
      S_IDLE: begin
        line_next = LINE_IDLE;
        if (!fifo_empty && ena) begin
          state_next = S_START;
          pop        = 1'b1;
        end
      end
      S_START: begin
        line_next = LINE_START;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        line_next = shift_q[0];
        if (bit_end && last_data) begin
`ifdef LNL_UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef LNL_UART_TX_PARITY_EN
      S_PARITY: begin
        line_next = parity_q;
        if (bit_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        line_next = LINE_STOP;
        if (bit_end) begin
          if (!fifo_empty && ena) begin
            state_next = S_START;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        line_next  = LINE_IDLE;
      end
    endcase
  end

  // busy tracks the line: on a pop it holds, so a fresh byte raises it with the start bit.
  assign busy_next = pop ? busy : ((state != S_IDLE) || (fifo_count != '0));

  // Shift register and baud/bit counters; divisor is captured only at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      div_q    <= DIV_W'(1);
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (pop) begin
      shift_q  <= fifo_head;
      div_q    <= (baud_div == '0) ? DIV_W'(1) : baud_div;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (state == S_DATA) begin
          shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end else begin
        baud_cnt <= baud_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd  <= LINE_IDLE;
      busy <= 1'b0;
    end else begin
      txd  <= line_next;
      busy <= busy_next;
    end
  end

endmodule

// File: doc/lnl_uart_tx.md
LNL_UART_TX -- requirements
Module: lnl_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of byte entries in the transmit FIFO (power of two, 2..16).
REQ-002 Parameter DIV_W, default 16, width of the baud divisor input.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable; when low no new frame starts, and a frame already in progress completes.
REQ-006 baud_div  input  DIV_W  clk cycles per serial bit.
REQ-007 wr_data  input  8  byte to transmit.
REQ-008 wr_valid  input  1  producer offers wr_data.
REQ-009 wr_ready  output  1  FIFO can accept a byte.
REQ-010 parity_odd  input  1  parity sense, used only when the parity feature is compiled in (0 = even, 1 = odd).
REQ-011 txd  output  1  serial line; idle high.
REQ-012 busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 A byte is accepted on a rising edge where wr_valid and wr_ready are both high; wr_ready is low exactly when the FIFO holds FIFO_DEPTH entries, with no same-cycle pass-through on pop.
REQ-014 Transmit FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
REQ-015 IDLE -> START when the FIFO is non-empty and ena=1; the head byte is popped into the shift register and baud_div is latched on that edge.
REQ-016 Latency: for a byte accepted into an empty FIFO while in IDLE, txd falls on the second rising edge after the accepting edge.
REQ-017 Every bit (start, data, parity, stop) is held for exactly the latched divisor in clk cycles; a latched value of 0 is treated as 1.
REQ-018 Frame bit order: start=0, data bits LSB first, then parity if present, then stop=1.
REQ-019 A baud_div change mid-frame takes effect only at the next frame start.
REQ-020 STOP -> START directly, with no idle bit, if the FIFO is non-empty and ena=1 at the end of the stop bit; otherwise STOP -> IDLE.
REQ-021 A write while full is ignored, with no overwrite and no error flag.
REQ-022 A write and a pop on the same edge are both performed and the count is unchanged.
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH; the count is one bit wider than the pointer.

Reset
REQ-024 rst_n low forces immediately: txd=1, busy=0, FSM=IDLE, FIFO empty.
REQ-025 wr_ready is 1 while rst_n is low.
REQ-026 A reset during a frame aborts the frame immediately, and the bytes in the FIFO are discarded.

Configuration
REQ-027 Macro LNL_UART_TX_PARITY_EN defined: the PARITY state is present and the frame is 11 bits; parity bit = XOR of data bits XOR parity_odd.
REQ-028 Macro LNL_UART_TX_PARITY_EN absent: the PARITY state is not generated, the frame is 10 bits, and parity_odd is ignored.

Structure
REQ-029 Shared package lnl_uart_pkg holds: the FSM state enum, the bit counts per frame, and the idle/start/stop line level constants.
REQ-030 The FIFO is a separate sub-module lnl_sync_fifo, parameterised by width and depth, with full, empty and count outputs.
REQ-031 The FSM, the baud counter and the shift register stay in lnl_uart_tx.

Verification
REQ-032 Test 1: baud_div=4, one write of 0x55 -> txd pattern 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; busy high for 40 cycles (44 with parity).
REQ-033 Test 2: baud_div=2, six back-to-back writes 0x01..0x06 -> wr_ready drops once 4 entries are buffered; all accepted bytes appear in order with no gap between frames.
REQ-034 Test 3: parity build, parity_odd=0, byte 0x07 -> parity bit 1; parity_odd=1 -> parity bit 0.
REQ-035 Test 4: baud_div=0, byte 0xA0 -> each bit lasts 1 cycle, frame is 10 cycles.
REQ-036 Test 5: rst_n pulled low in the middle of data bit 3 -> txd=1 and busy=0 in the same cycle; after release the FIFO is empty and no residual frame is sent.
REQ-037 Test 6: ena=0 with 2 bytes queued -> txd stays 1; ena=1 -> both frames are sent.
